serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Downstream consumer of the serial shift-register output (sout).
- Hunts the incoming bit stream for a fixed sync pattern, then deserializes a DATA_W-bit payload (MSB first) into a parallel word.
- Optionally checks one even-parity bit per frame.
- Hands the word to parallel logic with a one-cycle valid pulse.

Parameters:
DATA_W, 8, payload width in bits
SYNC_W, 4, sync pattern width in bits (2..8)
SYNC_PAT, 4'b1011, sync pattern; first-received bit is the MSB

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1
sin  input  1  serial data bit
dout  output  DATA_W  last received payload word, MSB = first payload bit
dout_valid  output  1  one-cycle pulse: dout updated
parity_err  output  1  parity result of the last frame, valid with dout_valid and held after
busy  output  1  high while in DATA or PARITY state

Behaviour:
- Reset: asynchronous and active-low; clk single clock.
- While rst=0: state=HUNT, history=0, fill count=0, bit count=0, dout=0, dout_valid=0, parity_err=0, busy=0.
- A "sample" is a rising clk edge with rst=1 and sin_en=1. On non-sample edges all state holds and dout_valid=0.
- HUNT:
  - Shift sin into a SYNC_W-1 bit history register.
  - Fill count saturates at SYNC_W-1.
  - Match when fill count = SYNC_W-1 and {history, sin} == SYNC_PAT. On match -> DATA, bit count=0.
  - No match: stay in HUNT. Overlapping patterns are detected, e.g. 1101011 matches on the 7th bit.
- DATA:
  - Shift sin into the payload register, MSB first; bit count increments per sample.
  - On the sample carrying payload bit DATA_W-1 -> PARITY (or completion if the feature is disabled, see below).
  - Sync patterns occurring inside the payload are ignored.
- PARITY:
  - Sample the parity bit. On that edge: dout<=payload, parity_err <= XOR(payload, parity bit), i.e. even parity required.
  - -> HUNT with history and fill count cleared.
- dout_valid:
  - High for exactly the clk cycle following the completing edge. Never high two consecutive cycles.
  - dout and parity_err hold until the next frame completes.
- Latency: dout visible one clk cycle after the edge sampling the final frame bit.
- Back-to-back frames: a sync pattern may start on the first sample after completion. A full SYNC_W bits are required; no history carries over.
- busy: 1 in DATA/PARITY, 0 in HUNT. Registered, so it changes on the edge of the state transition.
- Reset asserted mid-frame: partial payload discarded, immediate return to reset values, no dout_valid.
- Bit count width: clog2(DATA_W)+1; it never wraps within a frame.

Optional Feature:
- Macro: FRAME_PARITY_EN.
- Defined: PARITY state present, as described; frame length = SYNC_W+DATA_W+1 samples.
- Undefined:
  - No PARITY state. The sample carrying payload bit DATA_W-1 completes the frame: dout loads, dout_valid pulses next cycle, -> HUNT.
  - parity_err tied to 0.
  - Frame length = SYNC_W+DATA_W samples.

Test Plan:
1. Reset (rst=0, 2 cycles), then sin_en=1 continuously with bits 1011 10100101 0 -> dout=8'hA5, dout_valid high one cycle after the 13th sample, parity_err=0, busy low after completion.
2. Same frame with parity bit 1 -> dout=8'hA5, parity_err=1. Next frame 1011 00001111 0 -> dout=8'h0F, parity_err returns to 0.
3. Leading noise 110 then 1011 11110000 0, with sin_en toggling 1/0 every cycle -> dout=8'hF0 only after the 16th strobed sample; unstrobed cycles change nothing.
4. Payload containing the pattern: 1011 10111011 0 -> exactly one dout_valid, dout=8'hBB; no re-sync inside the payload.
5. Reset mid-frame: 1011 1010, drop rst for 1 cycle, then 1011 01010101 0 -> no pulse for the aborted frame; dout=8'h55, parity_err=0.
6. FRAME_PARITY_EN undefined: 1011 10100101 -> dout=8'hA5 valid after the 12th sample. Immediately following 1011 11111111 -> second dout_valid with dout=8'hFF, parity_err=0 throughout.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for SYNC_PAT, then deserializes a DATA_W-bit payload MSB first.
// Define FRAME_PARITY_EN to add a trailing even-parity bit per frame; otherwise parity_err stays 0.
module serial_frame_rx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int FILL_W = $clog2(SYNC_W);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_PARITY
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-2:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                busy_q, busy_d;

  // Window of the last SYNC_W received bits, newest in the LSB.
  logic [SYNC_W-1:0]   hunt_win;
  assign hunt_win = {hist_q, sin};

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves a signal unassigned (no latches).
    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    payload_d    = payload_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    parity_err_d = parity_err_q;

    if (sin_en) begin
      unique case (state_q)
        S_HUNT: begin
          hist_d = hunt_win[SYNC_W-2:0];
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
          if (fill_q == FILL_MAX && hunt_win == SYNC_PAT) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          payload_d = {payload_q[DATA_W-2:0], sin};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef FRAME_PARITY_EN
            state_d = S_PARITY;
`else
            dout_d       = payload_d;
            dout_valid_d = 1'b1;
            state_d      = S_HUNT;
            hist_d       = '0;
            fill_d       = '0;
`endif
          end
        end
        S_PARITY: begin
          dout_d       = payload_q;
          parity_err_d = (^payload_q) ^ sin;
          dout_valid_d = 1'b1;
          state_d      = S_HUNT;
          hist_d       = '0;
          fill_d       = '0;
        end
        default: state_d = S_HUNT;
      endcase
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HUNT;
      hist_q       <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      payload_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      payload_q    <= payload_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: driver pushes expected words, a negedge monitor pops and compares.
// Follows FRAME_PARITY_EN the same way the design does.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              sin_en;
  logic              sin;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              parity_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              p;
  } exp_t;

  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  serial_frame_rx #(.DATA_W(DATA_W), .SYNC_W(4), .SYNC_PAT(4'b1011)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin_en     (sin_en),
    .sin        (sin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every dout_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (prev_valid) check("valid_two_cycles", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, dout_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.p});
      end
    end
    prev_valid = dout_valid;
  end

  // Drive one cycle of inputs; returns #1 after the edge that saw them.
  task automatic step(input logic b, input logic en);
    sin    = b;
    sin_en = en;
    @(posedge clk);
    #1;
  endtask

  // One strobed bit, optionally preceded by an unstrobed cycle carrying junk on sin.
  task automatic strobe(input logic b, input bit toggle);
    logic busy_before;
    if (toggle) begin
      busy_before = busy;
      step(1'($urandom), 1'b0);
      check("unstrobed_busy_hold", {31'd0, busy}, {31'd0, busy_before});
    end
    step(b, 1'b1);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit toggle);
    for (int i = n - 1; i >= 0; i--) strobe(bits[i], toggle);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit,
                            input logic exp_perr, input bit toggle);
    exp_t e;
    e.d = d;
`ifdef FRAME_PARITY_EN
    e.p = exp_perr;
`else
    e.p = 1'b0;
`endif
    exp_q.push_back(e);
    send_bits(16'b1011, 4, toggle);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    for (int i = DATA_W - 1; i >= 0; i--) strobe(d[i], toggle);
`ifdef FRAME_PARITY_EN
    check("no_early_valid", {31'd0, dout_valid}, 32'd0);
    check("busy_in_parity", {31'd0, busy}, 32'd1);
    strobe(pbit, toggle);
`endif
    check("valid_latency", {31'd0, dout_valid}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b0;
    sin_en = 1'b0;
    sin    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    // 1: basic frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 2: bad parity, then a good frame clears it
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 3: leading noise forms an overlapping sync, strobe toggling
    send_bits(16'b110, 3, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // 4: sync pattern inside payload must not resync
    send_frame(8'hBB, 1'b0, 1'b0, 1'b0);
    idle(4);

    // 5: reset mid-frame discards the partial payload
    send_bits(16'b1011_1010, 8, 1'b0);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 6: back-to-back frames with no gap
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("dout_hold", {24'd0, dout}, 32'hFF);
    check("parity_err_hold", {31'd0, parity_err}, 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
